decode_issue: RTL and testbench

- Decode/issue stage that produces the `op`/`in1`/`in2` operand bundle consumed by the exec stage.
- Accepts a raw RV32I instruction word over a valid/ready handshake, decodes OP (0110011) and OP-IMM (0010011) instructions into the 6-bit ALU op codes from constants.v, and reads operands from an internal 32x32 register file.
- Issues through a one-entry output register.
- Owns the write-back port of the register file and a busy-bit scoreboard that stalls RAW/WAW hazards.

---
 rtl/decode_issue_if.sv | 31 +++
 rtl/decode_issue.sv | 212 +++++++++++++++++++++
 tb/tb_decode_issue.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_if.sv
// Bundle interface for decode_issue: instruction handshake, issued operand bundle,
// register-file write-back port and the illegal-instruction pulse.
interface decode_issue_if #(
  parameter int XLEN = 32
);
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic            ex_valid;
  logic            ex_ready;
  logic [5:0]      ex_op;
  logic [XLEN-1:0] ex_in1;
  logic [XLEN-1:0] ex_in2;
  logic [4:0]      ex_rd;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            illegal;

  // master: fetch/exec/write-back side driving the stage
  modport master (
    output instr_valid, instr, ex_ready, wb_en, wb_rd, wb_data,
    input  instr_ready, ex_valid, ex_op, ex_in1, ex_in2, ex_rd, illegal
  );

  // slave: the decode/issue stage itself
  modport slave (
    input  instr_valid, instr, ex_ready, wb_en, wb_rd, wb_data,
    output instr_ready, ex_valid, ex_op, ex_in1, ex_in2, ex_rd, illegal
  );
endinterface

// File: rtl/decode_issue.sv
// RV32I OP/OP-IMM decode and issue stage with register file, busy-bit scoreboard
// and a one-entry output register feeding the exec stage.
module decode_issue #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic           clk,
  input  logic           rst,
  decode_issue_if.slave  bus
);
  localparam int IDXW = $clog2(NREGS);

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_SLL   = 6'd2;
  localparam logic [5:0] OP_SLT   = 6'd3;
  localparam logic [5:0] OP_SLTU  = 6'd4;
  localparam logic [5:0] OP_XOR   = 6'd5;
  localparam logic [5:0] OP_SRL   = 6'd6;
  localparam logic [5:0] OP_SRA   = 6'd7;
  localparam logic [5:0] OP_OR    = 6'd8;
  localparam logic [5:0] OP_AND   = 6'd9;
  localparam logic [5:0] OP_ADDI  = 6'd10;
  localparam logic [5:0] OP_SLTI  = 6'd11;
  localparam logic [5:0] OP_SLTIU = 6'd12;
  localparam logic [5:0] OP_XORI  = 6'd13;
  localparam logic [5:0] OP_ORI   = 6'd14;
  localparam logic [5:0] OP_ANDI  = 6'd15;
  localparam logic [5:0] OP_SLLI  = 6'd16;
  localparam logic [5:0] OP_SRLI  = 6'd17;
  localparam logic [5:0] OP_SRAI  = 6'd18;

  logic [XLEN-1:0] rf_reg [NREGS];
  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] wb_hit;
  logic [NREGS-1:0] set_busy;
  logic [NREGS-1:0] busy_eff;

  logic            ex_valid_reg;
  logic [5:0]      ex_op_reg;
  logic [XLEN-1:0] ex_in1_reg;
  logic [XLEN-1:0] ex_in2_reg;
  logic [4:0]      ex_rd_reg;
  logic            illegal_reg;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [IDXW-1:0] rs1_idx;
  logic [IDXW-1:0] rs2_idx;
  logic [IDXW-1:0] rd_idx;

  logic            dec_legal;
  logic [5:0]      dec_op;
  logic            dec_r_type;
  logic            dec_shift;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] in2_val;
  logic            hazard;
  logic            instr_ready_w;
  logic            accept;

  assign opcode  = bus.instr[6:0];
  assign rd_idx  = bus.instr[11:7];
  assign funct3  = bus.instr[14:12];
  assign rs1_idx = bus.instr[19:15];
  assign rs2_idx = bus.instr[24:20];
  assign funct7  = bus.instr[31:25];

  // Per-register write port and busy bit; entry 0 never gets written or marked busy.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      assign wb_hit[gi]   = (gi != 0) && bus.wb_en && (bus.wb_rd == IDXW'(gi));
      assign set_busy[gi] = (gi != 0) && accept && dec_legal && (rd_idx == IDXW'(gi));
      assign busy_eff[gi] = busy_reg[gi] && !wb_hit[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          rf_reg[gi] <= '0;
        end else if (wb_hit[gi]) begin
          rf_reg[gi] <= bus.wb_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          busy_reg[gi] <= 1'b0;
        end else if (set_busy[gi]) begin
          busy_reg[gi] <= 1'b1;
        end else if (wb_hit[gi]) begin
          busy_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Reads bypass a same-cycle write-back so a waiting consumer issues in the wb cycle.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_idx != '0) rs1_val = wb_hit[rs1_idx] ? bus.wb_data : rf_reg[rs1_idx];
    if (rs2_idx != '0) rs2_val = wb_hit[rs2_idx] ? bus.wb_data : rf_reg[rs2_idx];
  end

  always_comb begin
    dec_legal  = 1'b0;
    dec_op     = OP_ADD;
    dec_r_type = 1'b0;
    dec_shift  = 1'b0;
    case (opcode)
      7'b0010011: begin
        dec_legal = 1'b1;
        case (funct3)
          3'b000: dec_op = OP_ADDI;
          3'b010: dec_op = OP_SLTI;
          3'b011: dec_op = OP_SLTIU;
          3'b100: dec_op = OP_XORI;
          3'b110: dec_op = OP_ORI;
          3'b111: dec_op = OP_ANDI;
          3'b001: begin
            dec_op    = OP_SLLI;
            dec_shift = 1'b1;
            dec_legal = (funct7 == 7'b0000000);
          end
          default: begin
            dec_shift = 1'b1;
            if (funct7 == 7'b0000000) begin
              dec_op = OP_SRLI;
            end else if (funct7 == 7'b0100000) begin
              dec_op = OP_SRAI;
            end else begin
              dec_legal = 1'b0;
            end
          end
        endcase
      end
      7'b0110011: begin
        dec_r_type = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          case (funct3)
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) begin
            dec_legal = 1'b1;
            dec_op    = OP_SUB;
          end else if (funct3 == 3'b101) begin
            dec_legal = 1'b1;
            dec_op    = OP_SRA;
          end
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    if (dec_r_type) begin
      in2_val = rs2_val;
    end else if (dec_shift) begin
      in2_val = {{(XLEN-5){1'b0}}, bus.instr[24:20]};
    end else begin
      in2_val = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
    end
  end

  // Illegal words carry no operands or destination, so they never stall.
  assign hazard = dec_legal &&
                  (busy_eff[rs1_idx] || (dec_r_type && busy_eff[rs2_idx]) || busy_eff[rd_idx]);

  assign instr_ready_w = (!ex_valid_reg || bus.ex_ready) && !hazard;
  assign accept        = bus.instr_valid && instr_ready_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg <= 1'b0;
      ex_op_reg    <= '0;
      ex_in1_reg   <= '0;
      ex_in2_reg   <= '0;
      ex_rd_reg    <= '0;
      illegal_reg  <= 1'b0;
    end else begin
      illegal_reg <= accept && !dec_legal;
      if (accept && dec_legal) begin
        ex_valid_reg <= 1'b1;
        ex_op_reg    <= dec_op;
        ex_in1_reg   <= rs1_val;
        ex_in2_reg   <= in2_val;
        ex_rd_reg    <= rd_idx;
      end else if (bus.ex_ready) begin
        ex_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.instr_ready = instr_ready_w;
  assign bus.ex_valid    = ex_valid_reg;
  assign bus.ex_op       = ex_op_reg;
  assign bus.ex_in1      = ex_in1_reg;
  assign bus.ex_in2      = ex_in2_reg;
  assign bus.ex_rd       = ex_rd_reg;
  assign bus.illegal     = illegal_reg;
endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: decode vector table plus handshake, hazard,
// stall and reset sequences.
module tb_decode_issue;
  localparam logic [5:0] ADD = 6'd0,  SUB = 6'd1,  SLL = 6'd2,  SLT = 6'd3,  SLTU = 6'd4;
  localparam logic [5:0] XOR_ = 6'd5, SRL = 6'd6,  SRA = 6'd7,  OR_ = 6'd8,  AND_ = 6'd9;
  localparam logic [5:0] ADDI = 6'd10, SLTI = 6'd11, SLTIU = 6'd12, XORI = 6'd13, ORI = 6'd14;
  localparam logic [5:0] ANDI = 6'd15, SLLI = 6'd16, SRLI = 6'd17, SRAI = 6'd18;

  typedef struct {
    logic [31:0] instr;
    logic        legal;
    logic [5:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs [25];

  decode_issue_if bus ();

  decode_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic vec_t mk(logic [31:0] instr, logic legal, logic [5:0] op,
                              logic [31:0] in1, logic [31:0] in2, logic [4:0] rd);
    vec_t v;
    v.instr = instr; v.legal = legal; v.op = op; v.in1 = in1; v.in2 = in2; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
    bus.wb_en = 1'b1; bus.wb_rd = rd; bus.wb_data = data;
    step();
    bus.wb_en = 1'b0;
    $display("wb    x%0d <= 0x%08h", rd, data);
  endtask

  // Present one instruction with ex_ready=1, expect acceptance, check the bundle one cycle later.
  task automatic apply(input string tag, input vec_t v);
    bus.instr = v.instr; bus.instr_valid = 1'b1; bus.ex_ready = 1'b1;
    #1;
    check({tag, ".ready"}, 32'(bus.instr_ready), 32'd1);
    step();
    bus.instr_valid = 1'b0;
    $display("issue %s instr=0x%08h valid=%0d op=%0d in1=0x%08h in2=0x%08h rd=%0d illegal=%0d",
             tag, v.instr, bus.ex_valid, bus.ex_op, bus.ex_in1, bus.ex_in2, bus.ex_rd, bus.illegal);
    check({tag, ".ex_valid"}, 32'(bus.ex_valid), 32'(v.legal));
    check({tag, ".illegal"}, 32'(bus.illegal), 32'(!v.legal));
    if (v.legal) begin
      check({tag, ".op"},  32'(bus.ex_op), 32'(v.op));
      check({tag, ".in1"}, bus.ex_in1, v.in1);
      check({tag, ".in2"}, bus.ex_in2, v.in2);
      check({tag, ".rd"},  32'(bus.ex_rd), 32'(v.rd));
    end
  endtask

  initial begin
    // preload: x4=80000000 x5=12345678 x6=0000000F x7=FFFFFFF0
    vecs[0]  = mk(enc_i(12'hFFF, 5, 3'd0, 10), 1, ADDI,  32'h12345678, 32'hFFFFFFFF, 10);
    vecs[1]  = mk(enc_i(12'h005, 7, 3'd2, 11), 1, SLTI,  32'hFFFFFFF0, 32'h00000005, 11);
    vecs[2]  = mk(enc_i(12'h7FF, 6, 3'd3, 12), 1, SLTIU, 32'h0000000F, 32'h000007FF, 12);
    vecs[3]  = mk(enc_i(12'h800, 4, 3'd4, 13), 1, XORI,  32'h80000000, 32'hFFFFF800, 13);
    vecs[4]  = mk(enc_i(12'h001, 6, 3'd6, 14), 1, ORI,   32'h0000000F, 32'h00000001, 14);
    vecs[5]  = mk(enc_i(12'h0FF, 5, 3'd7, 15), 1, ANDI,  32'h12345678, 32'h000000FF, 15);
    vecs[6]  = mk(enc_i(12'h004, 5, 3'd1, 16), 1, SLLI,  32'h12345678, 32'h00000004, 16);
    vecs[7]  = mk(enc_i(12'h001, 4, 3'd5, 17), 1, SRLI,  32'h80000000, 32'h00000001, 17);
    vecs[8]  = mk(enc_i(12'h41F, 4, 3'd5, 3),  1, SRAI,  32'h80000000, 32'h0000001F, 3);
    vecs[9]  = mk(enc_r(7'h00, 6, 5, 3'd0, 18), 1, ADD,  32'h12345678, 32'h0000000F, 18);
    vecs[10] = mk(enc_r(7'h20, 6, 5, 3'd0, 19), 1, SUB,  32'h12345678, 32'h0000000F, 19);
    vecs[11] = mk(enc_r(7'h00, 6, 7, 3'd1, 20), 1, SLL,  32'hFFFFFFF0, 32'h0000000F, 20);
    vecs[12] = mk(enc_r(7'h00, 4, 5, 3'd2, 21), 1, SLT,  32'h12345678, 32'h80000000, 21);
    vecs[13] = mk(enc_r(7'h00, 4, 5, 3'd3, 22), 1, SLTU, 32'h12345678, 32'h80000000, 22);
    vecs[14] = mk(enc_r(7'h00, 7, 6, 3'd4, 23), 1, XOR_, 32'h0000000F, 32'hFFFFFFF0, 23);
    vecs[15] = mk(enc_r(7'h00, 6, 4, 3'd5, 24), 1, SRL,  32'h80000000, 32'h0000000F, 24);
    vecs[16] = mk(enc_r(7'h20, 6, 4, 3'd5, 25), 1, SRA,  32'h80000000, 32'h0000000F, 25);
    vecs[17] = mk(enc_r(7'h00, 5, 6, 3'd6, 26), 1, OR_,  32'h0000000F, 32'h12345678, 26);
    vecs[18] = mk(enc_r(7'h00, 5, 6, 3'd7, 27), 1, AND_, 32'h0000000F, 32'h12345678, 27);
    vecs[19] = mk(enc_i(12'h404, 5, 3'd1, 28), 0, ADD, 0, 0, 0);
    vecs[20] = mk(enc_r(7'h20, 6, 5, 3'd1, 29), 0, ADD, 0, 0, 0);
    vecs[21] = mk(enc_i(12'h021, 4, 3'd5, 30), 0, ADD, 0, 0, 0);
    vecs[22] = mk(32'h00002003, 0, ADD, 0, 0, 0);
    vecs[23] = mk(enc_r(7'h01, 6, 5, 3'd0, 31), 0, ADD, 0, 0, 0);
    vecs[24] = mk(enc_r(7'h00, 6, 5, 3'd0, 0),  1, ADD,  32'h12345678, 32'h0000000F, 0);

    rst = 1'b1;
    bus.instr_valid = 1'b0; bus.instr = '0; bus.ex_ready = 1'b1;
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    @(negedge clk);
    step();
    rst = 1'b0;
    #1;
    check("reset.ex_valid", 32'(bus.ex_valid), 0);
    check("reset.ex_op",    32'(bus.ex_op), 0);
    check("reset.ex_in1",   bus.ex_in1, 0);
    check("reset.ex_in2",   bus.ex_in2, 0);
    check("reset.ex_rd",    32'(bus.ex_rd), 0);
    check("reset.illegal",  32'(bus.illegal), 0);
    check("reset.ready",    32'(bus.instr_ready), 1);

    // Decode table; writes to non-busy registers are plain writes.
    wb_write(4, 32'h80000000);
    wb_write(5, 32'h12345678);
    wb_write(6, 32'h0000000F);
    wb_write(7, 32'hFFFFFFF0);
    for (int i = 0; i < 25; i++) apply($sformatf("vec%0d", i), vecs[i]);

    rst = 1'b1; step(); rst = 1'b0;

    // addi x1,x0,-5 then RAW on x1 released by same-cycle write-back
    apply("addi_x1", mk(32'hFFB00093, 1, ADDI, 0, 32'hFFFFFFFB, 1));
    bus.instr = enc_r(7'h00, 1, 1, 3'd0, 2); bus.instr_valid = 1'b1;
    #1 check("raw.stall0", 32'(bus.instr_ready), 0);
    step();
    check("raw.stall1", 32'(bus.instr_ready), 0);
    bus.wb_en = 1'b1; bus.wb_rd = 1; bus.wb_data = 32'd7;
    #1 check("raw.bypass_ready", 32'(bus.instr_ready), 1);
    step();
    bus.wb_en = 1'b0; bus.instr_valid = 1'b0;
    $display("issue add_x2 valid=%0d op=%0d in1=0x%08h in2=0x%08h rd=%0d",
             bus.ex_valid, bus.ex_op, bus.ex_in1, bus.ex_in2, bus.ex_rd);
    check("raw.ex_valid", 32'(bus.ex_valid), 1);
    check("raw.op",  32'(bus.ex_op), 32'(ADD));
    check("raw.in1", bus.ex_in1, 32'd7);
    check("raw.in2", bus.ex_in2, 32'd7);
    check("raw.rd",  32'(bus.ex_rd), 2);

    // srai then illegal slli; illegal must not touch busy bits
    wb_write(4, 32'h80000000);
    apply("srai_x3", mk(enc_i(12'h41F, 4, 3'd5, 3), 1, SRAI, 32'h80000000, 32'd31, 3));
    apply("bad_slli", mk(enc_i(12'h404, 5, 3'd1, 8), 0, ADD, 0, 0, 0));
    step();
    check("bad_slli.pulse_end", 32'(bus.illegal), 0);
    check("bad_slli.ex_valid",  32'(bus.ex_valid), 0);
    bus.instr = enc_i(12'h000, 3, 3'd0, 9); bus.instr_valid = 1'b1;
    #1 check("busy3.still_set", 32'(bus.instr_ready), 0);
    bus.instr = enc_i(12'h000, 0, 3'd0, 8);
    #1 check("busy8.not_set", 32'(bus.instr_ready), 1);
    bus.instr_valid = 1'b0;
    wb_write(3, 32'd0);

    // Back-pressure: hold bundle 5 cycles, then release
    apply("ori_x10", mk(enc_i(12'h001, 0, 3'd6, 10), 1, ORI, 0, 32'd1, 10));
    bus.ex_ready = 1'b0;
    bus.instr = enc_i(12'h002, 0, 3'd6, 11); bus.instr_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("hold%0d.ready", c), 32'(bus.instr_ready), 0);
      check($sformatf("hold%0d.valid", c), 32'(bus.ex_valid), 1);
      check($sformatf("hold%0d.in2", c), bus.ex_in2, 32'd1);
      check($sformatf("hold%0d.rd", c), 32'(bus.ex_rd), 10);
      step();
    end
    bus.ex_ready = 1'b1;
    #1 check("release.ready", 32'(bus.instr_ready), 1);
    step();
    bus.instr_valid = 1'b0;
    check("release.valid", 32'(bus.ex_valid), 1);
    check("release.in2", bus.ex_in2, 32'd2);
    check("release.rd", 32'(bus.ex_rd), 11);

    // Four independent ori issued in four consecutive cycles
    for (int k = 0; k < 4; k++) begin
      bus.instr = enc_i(12'(k + 3), 0, 3'd6, 5'(12 + k)); bus.instr_valid = 1'b1;
      #1 check($sformatf("stream%0d.ready", k), 32'(bus.instr_ready), 1);
      step();
      $display("issue stream%0d valid=%0d in2=0x%08h rd=%0d", k, bus.ex_valid, bus.ex_in2, bus.ex_rd);
      check($sformatf("stream%0d.valid", k), 32'(bus.ex_valid), 1);
      check($sformatf("stream%0d.in2", k), bus.ex_in2, 32'(k + 3));
      check($sformatf("stream%0d.rd", k), 32'(bus.ex_rd), 32'(12 + k));
    end
    bus.instr_valid = 1'b0;

    // or x5,x5,x5 after addi x5: stalls until x5 write-back
    apply("addi_x5", mk(enc_i(12'h009, 0, 3'd0, 5), 1, ADDI, 0, 32'd9, 5));
    bus.instr = enc_r(7'h00, 5, 5, 3'd6, 5); bus.instr_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("or_stall%0d", c), 32'(bus.instr_ready), 0);
      step();
    end
    bus.wb_en = 1'b1; bus.wb_rd = 5; bus.wb_data = 32'd9;
    #1 check("or.ready_at_wb", 32'(bus.instr_ready), 1);
    step();
    bus.wb_en = 1'b0; bus.instr_valid = 1'b0;
    check("or.valid", 32'(bus.ex_valid), 1);
    check("or.op",  32'(bus.ex_op), 32'(OR_));
    check("or.in1", bus.ex_in1, 32'd9);
    check("or.in2", bus.ex_in2, 32'd9);
    check("or.rd",  32'(bus.ex_rd), 5);

    // Reset with a pending bundle and busy x5; x1 must read back as zero
    bus.ex_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst.ex_valid", 32'(bus.ex_valid), 0);
    check("midrst.ex_op",    32'(bus.ex_op), 0);
    bus.instr = enc_r(7'h00, 5, 1, 3'd0, 6); bus.instr_valid = 1'b1;
    #1 check("midrst.ready", 32'(bus.instr_ready), 1);
    step();
    bus.instr_valid = 1'b0;
    check("midrst.valid", 32'(bus.ex_valid), 1);
    check("midrst.x1", bus.ex_in1, 32'd0);
    check("midrst.x5", bus.ex_in2, 32'd0);

    wb_write(0, 32'hDEADBEEF);
    apply("x0_read", mk(enc_r(7'h00, 0, 0, 3'd0, 7), 1, ADD, 0, 0, 7));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
